vmem_arbiter: RTL and testbench

- Single-port arbiter and sequencer for the 64K x 16 video block RAM.
- Three requesters share the RAM:
  - video-decoder pixel write path
  - Amazon2 host SRAM-style bus (read/write with nWAIT)
  - corner-detector read port
- One RAM access per Sys_clk cycle. Fixed priority, with anti-starvation for the detector. Generates host wait handshake and read-data return for host and detector.

---
 rtl/vmem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_vmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_arbiter.sv
// ============================================================================
// Module   : vmem_arbiter
// Brief    : Single-port arbiter/sequencer for the 64K x 16 video block RAM
//            (video write, host bus with nWAIT, corner-detector reads).
// Revision : 1.0
// ============================================================================
`default_nettype none

module vmem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          Sys_clk,
    input  logic          reset,
    input  logic          vid_wr_stb,
    input  logic [AW-1:0] vid_wr_addr,
    input  logic [DW-1:0] vid_wr_data,
    input  logic          host_csx,
    input  logic          host_rdx,
    input  logic          host_wrx,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_waitx,
    input  logic          det_req,
    input  logic [AW-1:0] det_addr,
    output logic          det_gnt,
    output logic          det_rvalid,
    output logic [DW-1:0] det_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wren,
    output logic          ram_rden,
    input  logic [DW-1:0] ram_q,
    output logic [1:0]    owner
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] c_OWN_IDLE = 2'd0;
    localparam logic [1:0] c_OWN_VID  = 2'd1;
    localparam logic [1:0] c_OWN_HST  = 2'd2;
    localparam logic [1:0] c_OWN_DET  = 2'd3;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_REQ  = 2'd1,
        H_DATA = 2'd2,
        H_DONE = 2'd3
    } hst_state_t;

    hst_state_t        r_hst_state;
    hst_state_t        w_hst_next;
    logic [AW-1:0]     r_hst_addr;
    logic [DW-1:0]     r_hst_wdata;
    logic              r_hst_rd;
    logic [DW-1:0]     r_hst_rdata;
    logic [CW-1:0]     r_lat_cnt;

    logic              r_vid_pend;
    logic [AW-1:0]     r_vid_addr;
    logic [DW-1:0]     r_vid_data;

    logic [SW-1:0]     r_starve;
    logic [RD_LAT-1:0] r_det_vld;

    logic w_start, w_end, w_det_first, w_hst_cap;
    logic w_gnt_vid, w_gnt_hst, w_gnt_det;

    assign w_start     = !host_csx && (!host_rdx || !host_wrx);
    assign w_end       = host_csx || (host_rdx && host_wrx);
    assign w_det_first = (r_starve >= SW'(STARVE_MAX));
    assign w_hst_cap   = (r_hst_state == H_DATA) && (r_lat_cnt == CW'(RD_LAT - 1));

    // Fixed priority; a starved detector jumps ahead of the host only.
    always_comb begin
        w_gnt_vid = 1'b0;
        w_gnt_hst = 1'b0;
        w_gnt_det = 1'b0;
        if (!reset) begin
            if (r_vid_pend)                     w_gnt_vid = 1'b1;
            else if (det_req && w_det_first)    w_gnt_det = 1'b1;
            else if (r_hst_state == H_REQ)      w_gnt_hst = 1'b1;
            else if (det_req)                   w_gnt_det = 1'b1;
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wren  = 1'b0;
        ram_rden  = 1'b0;
        owner     = c_OWN_IDLE;
        if (w_gnt_vid) begin
            ram_addr  = r_vid_addr;
            ram_wdata = r_vid_data;
            ram_wren  = 1'b1;
            owner     = c_OWN_VID;
        end else if (w_gnt_hst) begin
            ram_addr = r_hst_addr;
            owner    = c_OWN_HST;
            if (r_hst_rd) begin
                ram_rden = 1'b1;
            end else begin
                ram_wren  = 1'b1;
                ram_wdata = r_hst_wdata;
            end
        end else if (w_gnt_det) begin
            ram_addr = det_addr;
            ram_rden = 1'b1;
            owner    = c_OWN_DET;
        end
    end

    // waitx drops in the very cycle the strobe is seen, before the FSM moves.
    always_comb begin
        w_hst_next = r_hst_state;
        host_waitx = 1'b1;
        case (r_hst_state)
            H_IDLE: begin
                if (w_start) begin
                    w_hst_next = H_REQ;
                    host_waitx = 1'b0;
                end
            end
            H_REQ: begin
                host_waitx = 1'b0;
                if (w_gnt_hst) w_hst_next = r_hst_rd ? H_DATA : H_DONE;
            end
            H_DATA: begin
                host_waitx = 1'b0;
                if (w_hst_cap) w_hst_next = H_DONE;
            end
            H_DONE: begin
                if (w_end) w_hst_next = H_IDLE;
            end
            default: w_hst_next = H_IDLE;
        endcase
        if (reset) host_waitx = 1'b1;
    end

    always_ff @(posedge Sys_clk) begin
        if (reset) begin
            r_hst_state <= H_IDLE;
            r_hst_addr  <= '0;
            r_hst_wdata <= '0;
            r_hst_rd    <= 1'b0;
            r_hst_rdata <= '0;
            r_lat_cnt   <= '0;
            r_vid_pend  <= 1'b0;
            r_vid_addr  <= '0;
            r_vid_data  <= '0;
            r_starve    <= '0;
            r_det_vld   <= '0;
        end else begin
            r_hst_state <= w_hst_next;
            if (r_hst_state == H_IDLE && w_start) begin
                r_hst_addr  <= host_addr;
                r_hst_wdata <= host_wdata;
                r_hst_rd    <= !host_rdx;
            end
            if (r_hst_state == H_DATA) r_lat_cnt <= w_hst_cap ? '0 : r_lat_cnt + 1'b1;
            if (w_hst_cap) r_hst_rdata <= ram_q;

            // A strobe in the issue cycle recaptures, keeping the slot busy.
            if (vid_wr_stb) begin
                r_vid_pend <= 1'b1;
                r_vid_addr <= vid_wr_addr;
                r_vid_data <= vid_wr_data;
            end else if (w_gnt_vid) begin
                r_vid_pend <= 1'b0;
            end

            if (!det_req || w_gnt_det)             r_starve <= '0;
            else if (r_starve < SW'(STARVE_MAX))   r_starve <= r_starve + 1'b1;

            r_det_vld <= (r_det_vld << 1) | RD_LAT'(w_gnt_det);
        end
    end

    assign det_gnt    = w_gnt_det;
    assign det_rvalid = !reset && r_det_vld[RD_LAT-1];
    assign det_rdata  = det_rvalid ? ram_q : '0;
    assign host_rdata = reset ? '0 : r_hst_rdata;

endmodule

`default_nettype wire

// File: tb/tb_vmem_arbiter.sv
// ============================================================================
// Module   : tb_vmem_arbiter
// Brief    : Directed-vector bench for vmem_arbiter with a 1-cycle RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          Sys_clk = 1'b0;
    logic          reset;
    logic          vid_wr_stb;
    logic [AW-1:0] vid_wr_addr;
    logic [DW-1:0] vid_wr_data;
    logic          host_csx, host_rdx, host_wrx;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_waitx;
    logic          det_req;
    logic [AW-1:0] det_addr;
    logic          det_gnt, det_rvalid;
    logic [DW-1:0] det_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren, ram_rden;
    logic [DW-1:0] ram_q;
    logic [1:0]    owner;

    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] r_q = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 Sys_clk = ~Sys_clk;

    vmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE_MAX(8)) u_dut (
        .Sys_clk     (Sys_clk),
        .reset       (reset),
        .vid_wr_stb  (vid_wr_stb),
        .vid_wr_addr (vid_wr_addr),
        .vid_wr_data (vid_wr_data),
        .host_csx    (host_csx),
        .host_rdx    (host_rdx),
        .host_wrx    (host_wrx),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .host_waitx  (host_waitx),
        .det_req     (det_req),
        .det_addr    (det_addr),
        .det_gnt     (det_gnt),
        .det_rvalid  (det_rvalid),
        .det_rdata   (det_rdata),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_wren    (ram_wren),
        .ram_rden    (ram_rden),
        .ram_q       (ram_q),
        .owner       (owner)
    );

    // Single-port RAM, read data valid one cycle after rden.
    always @(posedge Sys_clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        if (ram_rden) r_q <= mem[ram_addr];
    end
    assign ram_q = r_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mid();
        @(negedge Sys_clk);
    endtask

    task automatic next();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        vid_wr_stb = 1'b0;
        host_csx   = 1'b1;
        host_rdx   = 1'b1;
        host_wrx   = 1'b1;
        det_req    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] exp_own [12];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h8005] = 16'h1234;
        mem[16'h0020] = 16'hBEEF;
        exp_own = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd3};

        vid_wr_addr = '0; vid_wr_data = '0; host_addr = '0; host_wdata = '0; det_addr = '0;
        idle_inputs();

        // Reset held two cycles against an active host read and detector request
        reset = 1'b1; host_csx = 1'b0; host_rdx = 1'b0; host_addr = 16'h8005;
        det_req = 1'b1; det_addr = 16'h0020;
        for (int c = 0; c < 2; c++) begin
            mid();
            check("rst_waitx",  32'(host_waitx), 32'd1);
            check("rst_wren",   32'(ram_wren),   32'd0);
            check("rst_rden",   32'(ram_rden),   32'd0);
            check("rst_detgnt", 32'(det_gnt),    32'd0);
            check("rst_rvalid", 32'(det_rvalid), 32'd0);
            check("rst_owner",  32'(owner),      32'd0);
            next();
        end
        reset = 1'b0; idle_inputs();
        mid();
        check("post_rst_rdata", 32'(host_rdata), 32'h0);
        check("post_rst_owner", 32'(owner),      32'd0);
        check("post_rst_addr",  32'(ram_addr),   32'h0);
        next(); next();

        // Single video write
        vid_wr_stb = 1'b1; vid_wr_addr = 16'h0123; vid_wr_data = 16'hABCD;
        mid();
        check("vid_c0_wren", 32'(ram_wren), 32'd0);
        next(); vid_wr_stb = 1'b0;
        mid();
        check("vid_c1_wren",  32'(ram_wren),  32'd1);
        check("vid_c1_addr",  32'(ram_addr),  32'h0123);
        check("vid_c1_wdata", 32'(ram_wdata), 32'hABCD);
        check("vid_c1_owner", 32'(owner),     32'd1);
        next();
        mid();
        check("vid_c2_wren",  32'(ram_wren), 32'd0);
        check("vid_c2_owner", 32'(owner),    32'd0);
        next();

        // Host read of 0x8005
        host_csx = 1'b0; host_rdx = 1'b0; host_addr = 16'h8005;
        mid();
        check("hrd_c0_waitx", 32'(host_waitx), 32'd0);
        check("hrd_c0_rden",  32'(ram_rden),   32'd0);
        next(); mid();
        check("hrd_c1_waitx", 32'(host_waitx), 32'd0);
        check("hrd_c1_rden",  32'(ram_rden),   32'd1);
        check("hrd_c1_addr",  32'(ram_addr),   32'h8005);
        check("hrd_c1_owner", 32'(owner),      32'd2);
        next(); mid();
        check("hrd_c2_waitx", 32'(host_waitx), 32'd0);
        check("hrd_c2_rden",  32'(ram_rden),   32'd0);
        next(); mid();
        check("hrd_c3_waitx", 32'(host_waitx), 32'd1);
        check("hrd_c3_rdata", 32'(host_rdata), 32'h1234);
        next(); mid();
        check("hrd_c4_waitx", 32'(host_waitx), 32'd1);
        check("hrd_c4_rdata", 32'(host_rdata), 32'h1234);
        check("hrd_c4_rden",  32'(ram_rden),   32'd0);
        next(); idle_inputs(); next(); next();

        // Collision: video, host write and detector all contending from cycle 1
        vid_wr_stb = 1'b1; vid_wr_addr = 16'h0030; vid_wr_data = 16'h7777;
        host_csx = 1'b0; host_wrx = 1'b0; host_addr = 16'h0010; host_wdata = 16'h5555;
        mid();
        check("col_c0_waitx", 32'(host_waitx), 32'd0);
        check("col_c0_owner", 32'(owner),      32'd0);
        next(); vid_wr_stb = 1'b0; det_req = 1'b1; det_addr = 16'h0020;
        mid();
        check("col_c1_owner", 32'(owner),    32'd1);
        check("col_c1_addr",  32'(ram_addr), 32'h0030);
        check("col_c1_gnt",   32'(det_gnt),  32'd0);
        next(); mid();
        check("col_c2_owner", 32'(owner),     32'd2);
        check("col_c2_wren",  32'(ram_wren),  32'd1);
        check("col_c2_addr",  32'(ram_addr),  32'h0010);
        check("col_c2_wdata", 32'(ram_wdata), 32'h5555);
        check("col_c2_gnt",   32'(det_gnt),   32'd0);
        next(); mid();
        check("col_c3_owner", 32'(owner),      32'd3);
        check("col_c3_gnt",   32'(det_gnt),    32'd1);
        check("col_c3_rden",  32'(ram_rden),   32'd1);
        check("col_c3_addr",  32'(ram_addr),   32'h0020);
        check("col_c3_waitx", 32'(host_waitx), 32'd1);
        check("col_c3_rvld",  32'(det_rvalid), 32'd0);
        next(); idle_inputs();
        mid();
        check("col_c4_rvld",  32'(det_rvalid), 32'd1);
        check("col_c4_rdata", 32'(det_rdata),  32'hBEEF);
        check("col_c4_gnt",   32'(det_gnt),    32'd0);
        next(); mid();
        check("col_c5_rvld",  32'(det_rvalid), 32'd0);
        next(); next();

        // Starvation: eight video strobes hold off the detector and a host write
        det_addr = 16'h0020; host_addr = 16'h0040; host_wdata = 16'h1111;
        for (int c = 0; c < 12; c++) begin
            vid_wr_stb  = (c < 8);
            vid_wr_addr = 16'h0100 + 16'(c);
            vid_wr_data = 16'h0F00 + 16'(c);
            det_req     = (c >= 1);
            host_csx    = !(c >= 3 && c <= 10);
            host_wrx    = !(c >= 3 && c <= 10);
            mid();
            check($sformatf("stv_c%0d_owner", c), 32'(owner), 32'(exp_own[c]));
            if (c >= 1 && c <= 8)
                check($sformatf("stv_c%0d_addr", c), 32'(ram_addr), 32'h0100 + 32'(c - 1));
            if (c == 9) check("stv_c9_gnt", 32'(det_gnt), 32'd1);
            if (c == 10) begin
                check("stv_c10_wren",  32'(ram_wren),   32'd1);
                check("stv_c10_addr",  32'(ram_addr),   32'h0040);
                check("stv_c10_rvld",  32'(det_rvalid), 32'd1);
                check("stv_c10_rdata", 32'(det_rdata),  32'hBEEF);
            end
            next();
        end
        idle_inputs(); next(); next();

        // Reset during H_DATA with a detector request pending
        host_csx = 1'b0; host_rdx = 1'b0; host_addr = 16'h8005;
        next(); mid();
        check("rsd_c1_rden", 32'(ram_rden), 32'd1);
        next(); reset = 1'b1; det_req = 1'b1; det_addr = 16'h0020;
        mid();
        check("rsd_c2_waitx", 32'(host_waitx), 32'd1);
        check("rsd_c2_gnt",   32'(det_gnt),    32'd0);
        check("rsd_c2_rden",  32'(ram_rden),   32'd0);
        check("rsd_c2_rdata", 32'(host_rdata), 32'h0);
        next(); reset = 1'b0; idle_inputs();
        mid();
        check("rsd_c3_waitx", 32'(host_waitx), 32'd1);
        check("rsd_c3_rdata", 32'(host_rdata), 32'h0);
        check("rsd_c3_rvld",  32'(det_rvalid), 32'd0);
        check("rsd_c3_owner", 32'(owner),      32'd0);
        next();
        host_csx = 1'b0; host_wrx = 1'b0; host_addr = 16'h0050; host_wdata = 16'h2222;
        mid();
        check("rsd_c4_waitx", 32'(host_waitx), 32'd0);
        next(); mid();
        check("rsd_c5_wren",  32'(ram_wren), 32'd1);
        check("rsd_c5_addr",  32'(ram_addr), 32'h0050);
        check("rsd_c5_owner", 32'(owner),    32'd2);
        next(); idle_inputs(); next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
